// File: rtl/inst_buffer_pkg.sv
// Shared sizing and entry types for the instruction buffer.
package inst_buffer_pkg;
  localparam int BLOCK_INST_SIZE = 4;
  localparam int DECODE_WIDTH    = 4;
  localparam int IBUF_DEPTH      = 32;
  localparam int FSQ_WIDTH       = 5;

  localparam int OFF_W = $clog2(BLOCK_INST_SIZE);
  localparam int NUM_W = OFF_W + 1;
  localparam int PTR_W = $clog2(IBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ibuf_ptr_t;

  typedef struct packed {
    logic [31:0]          inst;
    logic [FSQ_WIDTH-1:0] fsq_idx;
    logic [OFF_W-1:0]     offset;
  } ibuf_entry_t;
endpackage

// File: rtl/inst_buffer_compactor.sv
// Exclusive prefix popcount of the slot enables: write offset of each slot past tail.
module inst_compactor
  import inst_buffer_pkg::*;
(
  input  logic [BLOCK_INST_SIZE-1:0]            in_en,
  output logic [BLOCK_INST_SIZE-1:0][NUM_W-1:0] wr_ofs
);
  logic [NUM_W-1:0] acc;

  always_comb begin
    acc    = '0;
    wr_ofs = '0;
    for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
      wr_ofs[i] = acc;
      acc       = acc + NUM_W'(in_en[i]);
    end
  end
endmodule

// File: rtl/inst_buffer.sv
// Circular instruction queue between predecode and decode: compacts enabled
// fetch slots on write, presents up to DECODE_WIDTH in-order entries on read.
module inst_buffer
  import inst_buffer_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [BLOCK_INST_SIZE-1:0]          in_en,
  input  logic [NUM_W-1:0]                    in_num,
  input  logic [BLOCK_INST_SIZE*32-1:0]       in_inst,
  input  logic [FSQ_WIDTH-1:0]                in_fsq_idx,
  output logic                                full,
  input  logic                                dec_ready,
  output logic [DECODE_WIDTH-1:0]             out_en,
  output logic [DECODE_WIDTH*32-1:0]          out_inst,
  output logic [DECODE_WIDTH*FSQ_WIDTH-1:0]   out_fsq_idx,
  output logic [DECODE_WIDTH*OFF_W-1:0]       out_offset
);
  ibuf_entry_t      mem [IBUF_DEPTH];
  ibuf_ptr_t        head, tail;
  logic [CNT_W-1:0] count, count_next, deq, wr_num;
  logic             wr;
  logic [BLOCK_INST_SIZE-1:0][NUM_W-1:0] wr_ofs;

  inst_compactor u_compactor (
    .in_en  (in_en),
    .wr_ofs (wr_ofs)
  );

  assign wr         = (|in_en) & ~full & ~flush;
  assign wr_num     = wr ? CNT_W'(in_num) : '0;
  assign deq        = !dec_ready ? '0 :
                      (count > CNT_W'(DECODE_WIDTH)) ? CNT_W'(DECODE_WIDTH) : count;
  assign count_next = count + wr_num - deq;

  // Full looks at next-cycle occupancy so any block seen while full=0 fits.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      head  <= head + ibuf_ptr_t'(deq);
      tail  <= tail + ibuf_ptr_t'(wr_num);
      count <= count_next;
      full  <= count_next > CNT_W'(IBUF_DEPTH - BLOCK_INST_SIZE);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
        if (in_en[i])
          mem[tail + ibuf_ptr_t'(wr_ofs[i])] <= '{inst:    in_inst[i*32 +: 32],
                                                  fsq_idx: in_fsq_idx,
                                                  offset:  OFF_W'(i)};
      end
    end
  end

  for (genvar k = 0; k < DECODE_WIDTH; k++) begin : g_lane
    ibuf_entry_t e;
    assign e                                     = mem[head + ibuf_ptr_t'(k)];
    assign out_en[k]                             = count > CNT_W'(k);
    assign out_inst[k*32 +: 32]                  = e.inst;
    assign out_fsq_idx[k*FSQ_WIDTH +: FSQ_WIDTH] = e.fsq_idx;
    assign out_offset[k*OFF_W +: OFF_W]          = e.offset;
  end
endmodule

// File: tb/tb_inst_buffer.sv
// Randomized bench for inst_buffer against a queue-based reference model.
module tb_inst_buffer;
  import inst_buffer_pkg::*;
  localparam int B  = BLOCK_INST_SIZE;
  localparam int DW = DECODE_WIDTH;
  localparam int D  = IBUF_DEPTH;
  localparam int FW = FSQ_WIDTH;
  localparam int OW = OFF_W;
  localparam int NW = NUM_W;

  logic clk = 1'b0, rst, flush, full, dec_ready;
  logic [B-1:0]       in_en;
  logic [NW-1:0]      in_num;
  logic [B*32-1:0]    in_inst;
  logic [FW-1:0]      in_fsq_idx;
  logic [DW-1:0]      out_en;
  logic [DW*32-1:0]   out_inst;
  logic [DW*FW-1:0]   out_fsq_idx;
  logic [DW*OW-1:0]   out_offset;

  typedef struct {
    logic [31:0] inst;
    logic [FW-1:0] fsq;
    int off;
  } ent_t;

  ent_t q[$];
  bit   m_full;
  int   errors = 0, checks = 0;

  inst_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .in_en(in_en), .in_num(in_num),
    .in_inst(in_inst), .in_fsq_idx(in_fsq_idx), .full(full), .dec_ready(dec_ready),
    .out_en(out_en), .out_inst(out_inst), .out_fsq_idx(out_fsq_idx), .out_offset(out_offset)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) assert (in_num == NW'($countones(in_en)))
      else $error("in_num does not match popcount(in_en)");
  end

  task automatic drive(input logic [B-1:0] en, input logic [FW-1:0] fsq,
                       input logic dr, input logic fl);
    in_en      = en;
    in_num     = NW'($countones(en));
    in_fsq_idx = fsq;
    dec_ready  = dr;
    flush      = fl;
    for (int i = 0; i < B; i++) in_inst[i*32 +: 32] = $urandom;
  endtask

  // Advance the reference model with the inputs currently applied, then the clock.
  task automatic tick();
    int n;
    if (rst || flush) begin
      q.delete();
      m_full = 1'b0;
    end else begin
      n = dec_ready ? ((q.size() < DW) ? q.size() : DW) : 0;
      repeat (n) void'(q.pop_front());
      if (|in_en && !m_full)
        for (int i = 0; i < B; i++)
          if (in_en[i]) q.push_back('{in_inst[i*32 +: 32], in_fsq_idx, i});
      m_full = q.size() > D - B;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    tick(); tick();
    checks++;
    if (out_en !== '0) begin errors++; $display("FAIL reset_out_en: got %b want 0", out_en); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    rst = 1'b0;
  endtask

  task automatic test_full_block();
    logic [B*32-1:0] ins;
    drive(4'b1111, 5'd3, 1'b1, 1'b0);
    ins = in_inst;
    tick();
    checks++;
    if (out_en !== 4'b1111) begin errors++; $display("FAIL blk4_en: got %b want 1111", out_en); end
    for (int k = 0; k < DW; k++) begin
      checks++;
      if (out_offset[k*OW +: OW] !== OW'(k) || out_fsq_idx[k*FW +: FW] !== 5'd3 ||
          out_inst[k*32 +: 32] !== ins[k*32 +: 32]) begin
        errors++;
        $display("FAIL blk4_lane%0d: got off=%0d fsq=%0d inst=%h want off=%0d fsq=3 inst=%h",
                 k, out_offset[k*OW +: OW], out_fsq_idx[k*FW +: FW], out_inst[k*32 +: 32],
                 k, ins[k*32 +: 32]);
      end
    end
    drive('0, '0, 1'b1, 1'b0);
    tick();
    checks++;
    if (out_en !== 4'b0000) begin errors++; $display("FAIL blk4_drain: got %b want 0000", out_en); end
  endtask

  task automatic test_partial();
    drive(4'b0110, 5'd7, 1'b1, 1'b0);
    in_inst[1*32 +: 32] = 32'hA;
    in_inst[2*32 +: 32] = 32'hB;
    tick();
    checks++;
    if (out_en !== 4'b0011 || out_inst[31:0] !== 32'hA || out_inst[63:32] !== 32'hB ||
        out_offset[OW-1:0] !== OW'(1) || out_offset[2*OW-1:OW] !== OW'(2)) begin
      errors++;
      $display("FAIL partial: got en=%b i0=%h i1=%h o0=%0d o1=%0d want en=0011 i0=a i1=b o0=1 o1=2",
               out_en, out_inst[31:0], out_inst[63:32], out_offset[OW-1:0], out_offset[2*OW-1:OW]);
    end
    drive('0, '0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_fill();
    for (int b = 0; b < 8; b++) begin
      drive(4'b1111, FW'(b), 1'b0, 1'b0);
      tick();
      if (b == 6) begin
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL fill_7_full: got %b want 0", full); end
      end
    end
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL fill_8_full: got %b want 1", full); end
    for (int c = 0; c < 2; c++) begin
      drive(4'b1111, 5'd9, 1'b0, 1'b0);
      tick();
      checks++;
      if (full !== 1'b1 || out_fsq_idx[FW-1:0] !== 5'd0) begin
        errors++;
        $display("FAIL fill_hold: got full=%b fsq0=%0d want full=1 fsq0=0", full, out_fsq_idx[FW-1:0]);
      end
    end
  endtask

  task automatic test_drain();
    int total = 0, cyc = 0;
    logic [B*32-1:0] held;
    bit accepted = 0;
    drive(4'b1111, 5'd9, 1'b1, 1'b0);
    held = in_inst;
    while (out_en !== '0 && cyc < 40) begin
      if (accepted) drive('0, '0, 1'b1, 1'b0);
      else begin
        in_en = 4'b1111; in_num = NW'(4); in_fsq_idx = 5'd9; in_inst = held;
        dec_ready = 1'b1; flush = 1'b0;
      end
      total += $countones(out_en);
      if (!m_full) accepted = 1;
      tick();
      cyc++;
      checks++;
      if (full !== m_full) begin errors++; $display("FAIL drain_full: got %b want %b", full, m_full); end
      for (int k = 0; k < DW; k++) begin
        checks++;
        if (out_en[k] !== (q.size() > k)) begin
          errors++; $display("FAIL drain_en%0d: got %b want %b", k, out_en[k], q.size() > k);
        end else if (k < q.size() && (out_inst[k*32 +: 32] !== q[k].inst ||
                 out_fsq_idx[k*FW +: FW] !== q[k].fsq || out_offset[k*OW +: OW] !== OW'(q[k].off))) begin
          errors++; $display("FAIL drain_lane%0d: got inst=%h want %h", k, out_inst[k*32 +: 32], q[k].inst);
        end
      end
    end
    checks++;
    if (total !== 36) begin errors++; $display("FAIL drain_total: got %0d want 36", total); end
  endtask

  task automatic test_random();
    int cyc;
    bit accepted;
    logic [B-1:0] en;
    logic [FW-1:0] fsq;
    for (int b = 0; b < 40; b++) begin
      en = B'($urandom_range(0, 15));
      fsq = FW'($urandom);
      accepted = 0;
      cyc = 0;
      while (!accepted && cyc < 200) begin
        drive(en, fsq, ($urandom_range(0, 3) != 0), 1'b0);
        accepted = !m_full;
        tick();
        cyc++;
        checks++;
        if (full !== m_full || q.size() > D) begin
          errors++; $display("FAIL rand_full: got %b want %b size=%0d", full, m_full, q.size());
        end
        for (int k = 0; k < DW; k++) begin
          checks++;
          if (out_en[k] !== (q.size() > k)) begin
            errors++; $display("FAIL rand_en%0d: got %b want %b", k, out_en[k], q.size() > k);
          end else if (k < q.size() && (out_inst[k*32 +: 32] !== q[k].inst ||
                   out_fsq_idx[k*FW +: FW] !== q[k].fsq || out_offset[k*OW +: OW] !== OW'(q[k].off))) begin
            errors++; $display("FAIL rand_lane%0d: got inst=%h off=%0d want inst=%h off=%0d", k,
                               out_inst[k*32 +: 32], out_offset[k*OW +: OW], q[k].inst, q[k].off);
          end
        end
      end
      checks++;
      if (!accepted) begin errors++; $display("FAIL rand_timeout: got stuck block %0d want accept", b); end
    end
  endtask

  task automatic test_flush();
    drive(4'b1111, 5'd1, 1'b0, 1'b0);
    tick();
    drive(4'b1111, 5'd2, 1'b1, 1'b1);
    tick();
    checks++;
    if (out_en !== '0 || full !== 1'b0) begin
      errors++; $display("FAIL flush_clear: got en=%b full=%b want en=0000 full=0", out_en, full);
    end
    drive('0, '0, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_en !== '0) begin errors++; $display("FAIL flush_no_write: got en=%b want 0000", out_en); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dec_ready = 1'b0;
    in_en = '0; in_num = '0; in_inst = '0; in_fsq_idx = '0;
    m_full = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_full_block();
    test_partial();
    test_fill();
    test_drain();
    test_random();
    test_flush();
    rst = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_en !== '0) begin errors++; $display("FAIL final_reset: got %b want 0000", out_en); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Instruction buffer that receives the predecoded fetch block from the predecode stage.
- Per cycle it accepts up to BLOCK_INST_SIZE instructions and compacts the enabled slots into a circular queue.
- Per cycle it presents up to DECODE_WIDTH in-order instructions to decode.
- It generates the ibuf_full backpressure that the predecode stage observes through frontend control, and it is flushed on any frontend redirect.

Parameters:
- BLOCK_INST_SIZE, 4, instructions per fetch block (write width); power of two.
- DECODE_WIDTH, 4, instructions presented to decode per cycle; must be ≤ DEPTH.
- DEPTH, 32, queue entries; power of two, ≥ 2*BLOCK_INST_SIZE.
- FSQ_WIDTH, 5, fetch stream queue index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  frontend redirect or predecode redirect; clears the queue
- in_en  in  BLOCK_INST_SIZE  per-slot valid from predecode (already masked by the predecode redirect)
- in_num  in  clog2(BLOCK_INST_SIZE)+1  popcount of in_en
- in_inst  in  BLOCK_INST_SIZE*32  raw instruction words, slot-ordered
- in_fsq_idx  in  FSQ_WIDTH  fetch stream index of the block
- full  out  1  ibuf_full; upstream holds its block while this is high
- dec_ready  in  1  decode can accept this cycle
- out_en  out  DECODE_WIDTH  per-lane valid to decode
- out_inst  out  DECODE_WIDTH*32  instruction per lane
- out_fsq_idx  out  DECODE_WIDTH*FSQ_WIDTH  fetch stream index per lane
- out_offset  out  DECODE_WIDTH*clog2(BLOCK_INST_SIZE)  original slot index within the fetch block

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: head=0, tail=0, count=0, full=0, out_en=0. Entry storage is not reset.
- Write accept: wr = |in_en & ~full & ~flush.
- Write placement:
  - Enabled slot i goes to entry tail + (number of enabled slots below i), modulo DEPTH.
  - Each written entry stores {inst, fsq_idx, offset=i}.
  - tail += in_num.
  - in_en may be any mask; relative order of enabled slots is preserved, and disabled slots are skipped.
- Read lanes:
  - out_en[k] = (count > k). This is combinational from registered state; no registered output latency.
  - Lane k shows entry head+k modulo DEPTH.
- Dequeue: deq = dec_ready ? min(count, DECODE_WIDTH) : 0. Then head += deq.
- Count update: count_next = count + (wr ? in_num : 0) - deq. Width is clog2(DEPTH)+1; it never exceeds DEPTH by construction.
- Full: registered, full <= ~flush & (count_next > DEPTH - BLOCK_INST_SIZE). A block arriving while full=0 therefore always fits.
- Stalled upstream: while full=1 the presented block is ignored and not duplicated. It is accepted in the first cycle full=0.
- Simultaneous write and read: allowed in the same cycle. A written entry is visible on out_* the next cycle at the earliest (no bypass).
- Wrap-around: head and tail wrap modulo DEPTH; the compaction offset add wraps the same way.
- Flush:
  - Highest priority: head, tail and count become 0 and full becomes 0 next cycle.
  - Any same-cycle write and dequeue are discarded.
  - out_en is 0 in the cycle after the flush.
- Reset mid-operation: identical to flush.
- in_num inconsistent with popcount(in_en) is illegal; a bench assertion flags it.

Decomposition:
- Shared package holds:
  - IBUF_DEPTH, DECODE_WIDTH, BLOCK_INST_SIZE, FSQ_WIDTH.
  - Typedef ibuf_entry_t {inst[31:0], fsq_idx, offset}.
  - Typedef ibuf_ptr_t of clog2(IBUF_DEPTH) bits.
- Sub-module inst_compactor: combinational exclusive prefix-popcount of in_en, producing per-slot write offsets. It can reuse the existing parallel adder.
- Queue, pointers and full logic stay in inst_buffer.

Test Plan:
- Reset, then in_en=1111, in_num=4, fsq=3, dec_ready=1 → next cycle out_en=1111, out_offset=0,1,2,3, out_fsq_idx=3 on all lanes; the cycle after, out_en=0000.
- in_en=0110, inst slot1=0xA, slot2=0xB → out lanes 0,1 = 0xA, 0xB with offsets 1,2; out_en=0011.
- dec_ready=0, eight blocks of 4 → full is 0 after the 7th block (count 28) and 1 after the 8th (count 32). A 9th block held while full is not written; count stays 32.
- From count 32, dec_ready=1 with the held block presented → deq 4/cycle. The held block is written exactly once after full drops; the total dequeued equals 36 in order.
- 40 blocks with random in_en masks and random dec_ready → output stream equals a reference-model compacted input order across pointer wrap; full is never violated.
- flush asserted in the same cycle as a write of 4 and a dequeue → next cycle count=0, full=0, out_en=0. The flushed write never appears on the outputs.
